norestore_div_iter: RTL

- Sequential, one-bit-per-cycle non-restoring divider. Reuses the same add/subtract-by-shifted-divisor step as the unrolled norestore cell array, with one step per clock.
- Sits upstream of consumers that need a W-bit quotient and remainder but cannot afford W cascaded cells.
- Owns the step loop, quotient collection, final remainder correction and valid/ready handshakes on both sides.

---
 rtl/norestore_pkg.sv | 22 ++
 rtl/norestore_step.sv | 26 ++
 rtl/norestore_div_iter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/norestore_pkg.sv
// Shared types and width helpers for the iterative non-restoring divider.
// Sizes follow from the operand width chosen at the top level.
package norestore_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  localparam int DEF_WIDTH = 4;

  function automatic int rem_w(input int w);
    return 2 * w + 1;
  endfunction

  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/norestore_step.sv
// One non-restoring step: add or subtract the divisor shifted by a
// runtime amount, depending on the sign of the partial remainder.
module norestore_step
  import norestore_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int RW    = rem_w(WIDTH),
  parameter int CW    = cnt_w(WIDTH)
) (
  input  logic [RW-1:0]    i_rem,
  input  logic [WIDTH-1:0] i_divisor,
  input  logic [CW-1:0]    i_shamt,
  output logic [RW-1:0]    o_rem_next,
  output logic             o_qbit
);

  logic [RW-1:0] w_d;

  assign w_d = {{(RW-WIDTH){1'b0}}, i_divisor} << i_shamt;

  always_comb begin
    o_rem_next = i_rem[RW-1] ? (i_rem + w_d) : (i_rem - w_d);
    o_qbit     = ~o_rem_next[RW-1];
  end

endmodule

// File: rtl/norestore_div_iter.sv
// Sequential one-bit-per-cycle non-restoring divider with valid/ready ports.
// Define NORESTORE_DIV_ZERO_FLAG_EN for the dbz flag and divide-by-zero bypass.
module norestore_div_iter
  import norestore_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
`ifdef NORESTORE_DIV_ZERO_FLAG_EN
  ,
  output logic             dbz
`endif
);

  localparam int RW = rem_w(WIDTH);
  localparam int CW = cnt_w(WIDTH);

  state_t           r_state;
  logic [RW-1:0]    r_rem;
  logic [WIDTH-1:0] r_div;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_q;

  logic [RW-1:0]    w_rem_next;
  logic             w_qbit;
  logic [RW-1:0]    w_fix;

  norestore_step #(
    .WIDTH (WIDTH),
    .RW    (RW),
    .CW    (CW)
  ) u_step (
    .i_rem      (r_rem),
    .i_divisor  (r_div),
    .i_shamt    (r_cnt),
    .o_rem_next (w_rem_next),
    .o_qbit     (w_qbit)
  );

  // Only the remainder needs a final restore; the quotient bits are exact.
  assign w_fix = r_rem[RW-1]
               ? r_rem + {{(RW-WIDTH){1'b0}}, r_div}
               : r_rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      din_ready  <= 1'b1;
      dout_valid <= 1'b0;
      quotient   <= '0;
      remainder  <= '0;
      r_rem      <= '0;
      r_div      <= '0;
      r_cnt      <= '0;
      r_q        <= '0;
`ifdef NORESTORE_DIV_ZERO_FLAG_EN
      dbz        <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          if (din_valid && din_ready) begin
            r_div     <= divisor;
            r_rem     <= {{(WIDTH+1){1'b0}}, dividend};
            r_cnt     <= CW'(WIDTH-1);
            r_q       <= '0;
            din_ready <= 1'b0;
            r_state   <= CALC;
`ifdef NORESTORE_DIV_ZERO_FLAG_EN
            if (divisor == '0) begin
              quotient   <= '1;
              remainder  <= dividend;
              dbz        <= 1'b1;
              dout_valid <= 1'b1;
              r_state    <= DONE;
            end
`endif
          end
        end
        CALC: begin
          r_rem        <= w_rem_next;
          r_q[r_cnt]   <= w_qbit;
          if (r_cnt == '0) begin
            r_state <= FIX;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        FIX: begin
          r_rem      <= w_fix;
          quotient   <= r_q;
          remainder  <= w_fix[WIDTH-1:0];
          dout_valid <= 1'b1;
`ifdef NORESTORE_DIV_ZERO_FLAG_EN
          dbz        <= 1'b0;
`endif
          r_state    <= DONE;
        end
        DONE: begin
          if (dout_ready) begin
            dout_valid <= 1'b0;
            din_ready  <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
